seq_display_timer: RTL
======================

// Module: seq_display_timer
// PURPOSE
//  Playback stage directly downstream of the FPGA sequence counter and its ROM.
//  On start, it shows the current ROM pattern on the LEDs for ON_TICKS cycles, then blanks them for GAP_TICKS cycles.
//  It then pulses cnt_en to advance the counter address and waits ROM_LAT cycles for the new ROM data.
//  This repeats until the counter's terminal carry (tc_in) is seen, then it reports done to the game controller.
// PARAMETERS
//  P_LED      4   width of the LED pattern word (ROM data width)
//  CNT_W      8   width of the internal tick timer
//  ON_TICKS   50  cycles each step is lit; legal range 1..2^CNT_W-1
//  GAP_TICKS  25  cycles LEDs are blank between steps; legal range 1..2^CNT_W-1
//  ROM_LAT    1   cycles from cnt_en to valid rom_data/tc_in; legal range 0..2^CNT_W-2
//  TONE_DIV   16  half-period of the tone output in clk cycles (tone option only)
// PORTS
//  clk       in   1      clock; all logic on posedge
//  R         in   1      synchronous active-high reset
//  start     in   1      begin playback; sampled in IDLE only
//  rom_data  in   P_LED  LED pattern from the ROM at the current counter address
//  tc_in     in   1      terminal carry from the sequence counter (level)
//  cnt_en    out  1      1-cycle advance pulse, drives the counter enable E
//  leds      out  P_LED  registered LED drive
//  busy      out  1      high in every state except IDLE
//  done      out  1      1-cycle pulse: round playback finished
//  tone      out  1      buzzer square wave (tone option only; otherwise tied 0)
// BEHAVIOUR
//  - States: IDLE, SHOW, GAP, ADV, DONE. All outputs are registered.
//  - Reset: R=1 at a posedge forces IDLE, timer=0, leds=0, cnt_en=0, done=0, busy=0, tone=0.
//    Reset applies from any state, including mid-playback; it has priority over start.
//  - IDLE: start=1 -> SHOW; leds<=rom_data and timer<=0 on the same edge. start=0 -> remain in IDLE.
//  - SHOW: lasts exactly ON_TICKS cycles; leds hold the value latched on entry.
//    At the end of SHOW -> GAP; leds<=0.
//  - GAP: lasts exactly GAP_TICKS cycles. At the end of GAP -> ADV; cnt_en<=1 for exactly one cycle.
//  - ADV: lasts exactly ROM_LAT+1 cycles; tc_in is sampled in the last ADV cycle.
//    tc_in=1 -> DONE. tc_in=0 -> SHOW; leds<=rom_data and timer<=0.
//  - DONE: one cycle; done=1 and busy=1. Next state is IDLE.
//  - Step period = ON_TICKS+GAP_TICKS+ROM_LAT+1 cycles.
//    If start is sampled at edge k, the first SHOW cycle is k+1.
//  - The timer compares against the parameter minus 1 and resets on every state change; it never wraps.
//  - start while busy: ignored, no restart. tc_in outside the last ADV cycle: ignored.
//  - tc_in already 1 at start: exactly one step is shown, then DONE.
//  - cnt_en is never asserted in IDLE, SHOW, or DONE.
// CONFIGURATION
//  SEQ_DISPLAY_TONE_EN defined:
//    - tone toggles every TONE_DIV cycles while in SHOW.
//    - tone is forced to 0 in all other states; the divider restarts at each SHOW entry.
//  SEQ_DISPLAY_TONE_EN undefined:
//    - No divider logic is built; tone is constant 0.
// TESTING (ON_TICKS=3, GAP_TICKS=2, ROM_LAT=1; bench models counter+ROM)
//  1. Reset: hold R for 2 cycles while toggling start -> leds=0, busy=0, cnt_en=0, done=0 throughout.
//  2. Single step: tc_in=1, rom_data=4'b0100, start pulse at edge k
//     -> leds=0100 on k+1..k+3; leds=0 on k+4..k+5; cnt_en on k+6; done on k+8; busy=0 from k+9.
//  3. Three steps: ROM returns 0001/0010/1000; counter model raises tc_in on the 3rd cnt_en
//     -> three SHOW windows with those patterns; cnt_en pulses at k+6, k+13, k+20; done at k+22.
//  4. Start while busy: extra start pulses during SHOW and GAP -> timing is identical to scenario 3.
//  5. Mid-operation reset: R at the 2nd SHOW cycle -> IDLE on the next edge with all outputs 0;
//     a new start then replays from step 1 timing.
//  6. SEQ_DISPLAY_TONE_EN with TONE_DIV=1 -> tone toggles every cycle in SHOW and is 0 in GAP, ADV, and IDLE;
//     without the macro, tone is constant 0.

Source files
------------

// File: rtl/seq_display_timer.sv
// Sequence playback timer: shows each ROM pattern, blanks, advances the counter, repeats until terminal carry.
// Optional buzzer output enabled by defining SEQ_DISPLAY_TONE_EN.
module seq_display_timer #(
  parameter int P_LED     = 4,
  parameter int CNT_W     = 8,
  parameter int ON_TICKS  = 50,
  parameter int GAP_TICKS = 25,
  parameter int ROM_LAT   = 1,
  parameter int TONE_DIV  = 16
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic [P_LED-1:0] rom_data,
  input  logic             tc_in,
  output logic             cnt_en,
  output logic [P_LED-1:0] leds,
  output logic             busy,
  output logic             done,
  output logic             tone
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW,
    S_GAP,
    S_ADV,
    S_DONE
  } state_t;

  // Each state ends when the timer reaches its duration minus one.
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] ADV_LAST = CNT_W'(ROM_LAT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [P_LED-1:0] leds_q, leds_d;
  logic             cnt_en_q, cnt_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    leds_d   = leds_q;
    cnt_en_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (start) begin
          state_d = S_SHOW;
          leds_d  = rom_data;
        end
      end
      S_SHOW: begin
        if (timer_q == ON_LAST) begin
          state_d = S_GAP;
          timer_d = '0;
          leds_d  = '0;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          state_d  = S_ADV;
          timer_d  = '0;
          cnt_en_d = 1'b1;
        end
      end
      S_ADV: begin
        // tc_in and rom_data are only trusted once the ROM latency has elapsed.
        if (timer_q == ADV_LAST) begin
          timer_d = '0;
          if (tc_in) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHOW;
            leds_d  = rom_data;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        timer_d = '0;
        leds_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        leds_d  = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      leds_q   <= '0;
      cnt_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      leds_q   <= leds_d;
      cnt_en_q <= cnt_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cnt_en = cnt_en_q;
  assign leds   = leds_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef SEQ_DISPLAY_TONE_EN
  localparam int TD_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TD_W-1:0] DIV_LAST = TD_W'(TONE_DIV - 1);

  logic [TD_W-1:0] div_q, div_d;
  logic            tone_q, tone_d;

  // Divider restarts on every SHOW entry so each step's tone starts in phase.
  always_comb begin
    div_d  = '0;
    tone_d = 1'b0;
    if (state_d == S_SHOW && state_q == S_SHOW) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tone_d = ~tone_q;
      end else begin
        div_d  = div_q + 1'b1;
        tone_d = tone_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      div_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;
`else
  localparam int tone_div_unused = TONE_DIV;
  assign tone = 1'b0;
`endif

endmodule
